// File: rtl/sweep_if.sv
// Handshake/config/output bundle between a sweep master and the sweep_ctrl engine.
interface sweep_if #(
    parameter int N = 32,
    parameter int W = 16
);
    logic         start;
    logic         abort;
    logic [N-1:0] cfg_base;
    logic [N-1:0] cfg_step;
    logic [W-1:0] cfg_count;
    logic [W-1:0] cfg_dwell;
    logic         cfg_mode;
    logic [N-1:0] duty_in;
    logic [N-1:0] ctrl;
    logic [N-1:0] duty;
    logic         gate;
    logic         busy;
    logic         done;
    logic [W-1:0] step_idx;

    modport master (
        output start, abort, cfg_base, cfg_step, cfg_count, cfg_dwell, cfg_mode, duty_in,
        input  ctrl, duty, gate, busy, done, step_idx
    );

    modport slave (
        input  start, abort, cfg_base, cfg_step, cfg_count, cfg_dwell, cfg_mode, duty_in,
        output ctrl, duty, gate, busy, done, step_idx
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Frequency sweep sequencer: steps an oscillator control word from a base value,
// holding each step for a dwell period, one-shot or ping-pong.
module sweep_ctrl #(
    parameter int N = 32,
    parameter int W = 16
) (
    input logic    clk,
    input logic    rst,
    sweep_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic        [N-1:0] ctrl_q, ctrl_d;
    logic        [N-1:0] duty_q, duty_d;
    logic                gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic        [W-1:0] step_idx_q, step_idx_d;
    logic                dir_q, dir_d;          // 0 = up, 1 = down
    logic        [W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic signed [N-1:0] step_q, step_d;
    logic        [W-1:0] count_q, count_d;
    logic        [W-1:0] dwell_q, dwell_d;      // already clamped to >= 1
    logic                mode_q, mode_d;

    // A zero dwell would stall the sweep forever, so it is treated as one clock.
    function automatic logic [W-1:0] clamp_dwell(input logic [W-1:0] d);
        return (d == '0) ? W'(1) : d;
    endfunction

    // Modulo-2^N step in either direction; wraparound is intentional.
    function automatic logic [N-1:0] step_ctrl(input logic [N-1:0] c,
                                               input logic signed [N-1:0] s,
                                               input logic down);
        return down ? (c - N'(s)) : (c + N'(s));
    endfunction

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        duty_d      = duty_q;
        gate_d      = gate_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        step_idx_d  = step_idx_q;
        dir_d       = dir_q;
        dwell_cnt_d = dwell_cnt_q;
        step_d      = step_q;
        count_d     = count_q;
        dwell_d     = dwell_q;
        mode_d      = mode_q;

        case (state_q)
            IDLE: begin
                ctrl_d     = '0;
                duty_d     = '0;
                gate_d     = 1'b0;
                busy_d     = 1'b0;
                step_idx_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d     = RUN;
                    ctrl_d      = bus.cfg_base;
                    duty_d      = bus.duty_in;
                    gate_d      = 1'b1;
                    busy_d      = 1'b1;
                    dir_d       = 1'b0;
                    step_d      = signed'(bus.cfg_step);
                    count_d     = bus.cfg_count;
                    dwell_d     = clamp_dwell(bus.cfg_dwell);
                    mode_d      = bus.cfg_mode;
                    dwell_cnt_d = clamp_dwell(bus.cfg_dwell);
                end
            end

            RUN: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    ctrl_d     = '0;
                    duty_d     = '0;
                    gate_d     = 1'b0;
                    busy_d     = 1'b0;
                    step_idx_d = '0;
                end else if (dwell_cnt_q > W'(1)) begin
                    dwell_cnt_d = dwell_cnt_q - W'(1);
                end else if (step_idx_q != count_q) begin
                    ctrl_d      = step_ctrl(ctrl_q, step_q, dir_q);
                    duty_d      = bus.duty_in;
                    step_idx_d  = step_idx_q + W'(1);
                    dwell_cnt_d = dwell_q;
                end else if (mode_q) begin
                    // Ping-pong turnaround: the end value is held for one more dwell.
                    dir_d       = ~dir_q;
                    step_idx_d  = '0;
                    dwell_cnt_d = dwell_q;
                end else begin
                    state_d = DONE;
                    gate_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            DONE: begin
                state_d    = IDLE;
                ctrl_d     = '0;
                duty_d     = '0;
                gate_d     = 1'b0;
                busy_d     = 1'b0;
                step_idx_d = '0;
            end

            default: begin
                state_d    = IDLE;
                ctrl_d     = '0;
                duty_d     = '0;
                gate_d     = 1'b0;
                busy_d     = 1'b0;
                step_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            duty_q      <= '0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            step_idx_q  <= '0;
            dir_q       <= 1'b0;
            dwell_cnt_q <= '0;
            step_q      <= '0;
            count_q     <= '0;
            dwell_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            duty_q      <= duty_d;
            gate_q      <= gate_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            step_idx_q  <= step_idx_d;
            dir_q       <= dir_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_q      <= step_d;
            count_q     <= count_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
        end
    end

    assign bus.ctrl     = ctrl_q;
    assign bus.duty     = duty_q;
    assign bus.gate     = gate_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_idx_q;

endmodule
